// File: rtl/sad_row_sequencer_if.sv
// Row-producer / result-consumer bundle for sad_row_sequencer.
// The slave modport is the sequencer side, and the master modport is the producer/consumer side.
interface sad_row_sequencer_if #(
  parameter int WIN   = 11,
  parameter int PIX_W = 8,
  parameter int SUM_W = 16
);
  localparam int IDX_W = (WIN > 1) ? $clog2(WIN) : 1;

  logic                   start;
  logic                   abort;
  logic [SUM_W-1:0]       threshold;
  logic [WIN*PIX_W-1:0]   row_data;
  logic                   row_valid;
  logic                   row_ready;
  logic [SUM_W-1:0]       sum;
  logic                   sum_valid;
  logic                   sum_ready;
  logic                   motion;
  logic                   busy;
  logic [IDX_W-1:0]       peak_row;

  modport master (
    output start, abort, threshold, row_data, row_valid, sum_ready,
    input  row_ready, sum, sum_valid, motion, busy, peak_row
  );

  modport slave (
    input  start, abort, threshold, row_data, row_valid, sum_ready,
    output row_ready, sum, sum_valid, motion, busy, peak_row
  );
endinterface

// File: rtl/sad_row_sequencer.sv
// Accumulates WIN rows of pixel differences through one shared row adder into an 11x11 SAD and a motion flag.
// Defining SAD_PEAK_EN enables peak-row tracking; without it, peak_row is tied to 0.
module sad_row_sequencer #(
  parameter int WIN   = 11,
  parameter int PIX_W = 8,
  parameter int SUM_W = 16
) (
  input  logic                iCLK,
  input  logic                iRST_N,
  sad_row_sequencer_if.slave  bus
);
  localparam int IDX_W = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int RS_W  = PIX_W + IDX_W;
  localparam int EXT_W = ((SUM_W > RS_W) ? SUM_W : RS_W) + 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  state_t             r_state;
  logic [SUM_W-1:0]   r_acc;
  logic [IDX_W-1:0]   r_cnt;
  logic [SUM_W-1:0]   r_thr;
  logic [SUM_W-1:0]   r_sum;
  logic               r_motion;
  logic               r_sum_valid;
  logic               r_busy;

  logic [RS_W-1:0]    w_rowsum;
  logic [EXT_W-1:0]   w_add;
  logic [SUM_W-1:0]   w_next;
  logic               w_accept;
  logic               w_last;

  always_comb begin
    w_rowsum = '0;
    for (int unsigned k = 0; k < WIN; k++) begin
      w_rowsum = w_rowsum + RS_W'(bus.row_data[k*PIX_W +: PIX_W]);
    end
  end

  // Widened add so an overflow is visible and can saturate to all ones.
  assign w_add    = EXT_W'(r_acc) + EXT_W'(w_rowsum);
  assign w_next   = (w_add > EXT_W'({SUM_W{1'b1}})) ? '1 : w_add[SUM_W-1:0];
  assign w_accept = bus.row_valid & (r_state == S_ACCUM);
  assign w_last   = (r_cnt == IDX_W'(WIN - 1));

`ifdef SAD_PEAK_EN
  logic [RS_W-1:0]    r_peak_val;
  logic [IDX_W-1:0]   r_peak_idx;
  logic [IDX_W-1:0]   r_peak_row;
  logic               w_new_peak;

  assign w_new_peak   = (w_rowsum > r_peak_val);
  assign bus.peak_row = r_peak_row;
`else
  assign bus.peak_row = '0;
`endif

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_thr       <= '0;
      r_sum       <= '0;
      r_motion    <= 1'b0;
      r_sum_valid <= 1'b0;
      r_busy      <= 1'b0;
`ifdef SAD_PEAK_EN
      r_peak_val  <= '0;
      r_peak_idx  <= '0;
      r_peak_row  <= '0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (!bus.abort && bus.start) begin
            r_state    <= S_ACCUM;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_thr      <= bus.threshold;
            r_busy     <= 1'b1;
`ifdef SAD_PEAK_EN
            r_peak_val <= '0;
            r_peak_idx <= '0;
`endif
          end
        end
        S_ACCUM: begin
          if (bus.abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (w_accept) begin
            r_acc <= w_next;
            r_cnt <= r_cnt + IDX_W'(1);
`ifdef SAD_PEAK_EN
            if (w_new_peak) begin
              r_peak_val <= w_rowsum;
              r_peak_idx <= r_cnt;
            end
`endif
            if (w_last) begin
              r_state     <= S_DONE;
              r_sum       <= w_next;
              r_motion    <= (w_next > r_thr);
              r_sum_valid <= 1'b1;
`ifdef SAD_PEAK_EN
              r_peak_row  <= w_new_peak ? r_cnt : r_peak_idx;
`endif
            end
          end
        end
        S_DONE: begin
          if (bus.abort || bus.sum_ready) begin
            r_state     <= S_IDLE;
            r_sum_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_sum_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.row_ready = (r_state == S_ACCUM);
  assign bus.sum       = r_sum;
  assign bus.sum_valid = r_sum_valid;
  assign bus.motion    = r_motion;
  assign bus.busy      = r_busy;
endmodule
